// File: rtl/core_pkg.sv
// Shared core types for writeback arbitration: widths, the request bundle
// and the source identifiers used by round-robin arbiters.
package core_pkg;

    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = $clog2(NUM_REGS);

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Issue, writeback and register-file write port bundle around the arbiter.
// Signal suffixes are from the arbiter's point of view.
interface regfile_wb_arbiter_if;
    import core_pkg::*;

    logic                  issue_valid_i;
    logic [REG_ADDR_W-1:0] issue_rd_i;
    logic [REG_ADDR_W-1:0] issue_rs1_i;
    logic [REG_ADDR_W-1:0] issue_rs2_i;
    logic                  issue_stall_o;
    logic                  alu_valid_i;
    logic [REG_ADDR_W-1:0] alu_rd_i;
    logic [XLEN-1:0]       alu_data_i;
    logic                  alu_ready_o;
    logic                  lsu_valid_i;
    logic [REG_ADDR_W-1:0] lsu_rd_i;
    logic [XLEN-1:0]       lsu_data_i;
    logic                  lsu_ready_o;
    logic [REG_ADDR_W-1:0] rf_rd_o;
    logic [XLEN-1:0]       rf_data_o;
    logic                  wb_err_o;

    modport slave (
        input  issue_valid_i, issue_rd_i, issue_rs1_i, issue_rs2_i,
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  lsu_valid_i, lsu_rd_i, lsu_data_i,
        output issue_stall_o, alu_ready_o, lsu_ready_o,
        output rf_rd_o, rf_data_o, wb_err_o
    );

    modport master (
        output issue_valid_i, issue_rd_i, issue_rs1_i, issue_rs2_i,
        output alu_valid_i, alu_rd_i, alu_data_i,
        output lsu_valid_i, lsu_rd_i, lsu_data_i,
        input  issue_stall_o, alu_ready_o, lsu_ready_o,
        input  rf_rd_o, rf_data_o, wb_err_o
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// Two-way round-robin arbiter. Index 0 is the ALU-side requester, index 1 the
// LSU side; the last-grant register only moves when both request together.
module wb_rr_arbiter
    import core_pkg::*;
(
    input  logic       clk,
    input  logic       rstn_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    wb_src_e    last_q;
    wb_src_e    last_d;
    logic [1:0] gnt_s;

    // Grant selection and last-grant update for contested cycles
    always_comb begin
        gnt_s  = 2'b00;
        last_d = last_q;
        if (req_i == 2'b11) begin
            if (last_q == WB_LSU) begin
                gnt_s  = 2'b01;
                last_d = WB_ALU;
            end else begin
                gnt_s  = 2'b10;
                last_d = WB_LSU;
            end
        end else begin
            gnt_s = req_i;
        end
    end

    // Last-grant register; LSU after reset so the ALU wins the first contest
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            last_q <= WB_LSU;
        end else begin
            last_q <= last_d;
        end
    end

    assign gnt_o = gnt_s;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: arbitrates ALU/LSU writebacks into a
// registered write port and tracks per-register busy bits for issue hazards.
module regfile_wb_arbiter
    import core_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn_i,
    regfile_wb_arbiter_if.slave  bus
);

    localparam logic [NUM_REGS-1:0] REG_ONE_HOT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic [REG_ADDR_W-1:0] rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]       rf_data_q, rf_data_d;
    logic                  wb_err_q, wb_err_d;
    logic [NUM_REGS-1:0]   clr_mask_s, set_mask_s;
    logic                  stall_s;
    logic                  issue_acc_s;
    logic [1:0]            gnt_s;
    wb_req_t               alu_req_s, lsu_req_s, sel_s;

    wb_rr_arbiter u_arb (
        .clk    (clk),
        .rstn_i (rstn_i),
        .req_i  ({lsu_req_s.valid, alu_req_s.valid}),
        .gnt_o  (gnt_s)
    );

    // Hazard check, writeback selection and scoreboard next state
    always_comb begin
        alu_req_s   = '{valid: bus.alu_valid_i, rd: bus.alu_rd_i, data: bus.alu_data_i};
        lsu_req_s   = '{valid: bus.lsu_valid_i, rd: bus.lsu_rd_i, data: bus.lsu_data_i};
        stall_s     = bus.issue_valid_i & (busy_q[bus.issue_rs1_i] |
                                           busy_q[bus.issue_rs2_i] |
                                           busy_q[bus.issue_rd_i]);
        issue_acc_s = bus.issue_valid_i & ~stall_s;

        if (gnt_s[0]) begin
            sel_s = alu_req_s;
        end else if (gnt_s[1]) begin
            sel_s = lsu_req_s;
        end else begin
            sel_s = '0;
        end
        rf_rd_d   = sel_s.valid ? sel_s.rd : {REG_ADDR_W{1'b0}};
        rf_data_d = sel_s.data;

        // The write being presented now lands at the next edge, so its busy bit
        // clears there; an issue set on the same index still wins.
        clr_mask_s = REG_ONE_HOT0 << rf_rd_q;
        set_mask_s = issue_acc_s ? (REG_ONE_HOT0 << bus.issue_rd_i) : {NUM_REGS{1'b0}};
        busy_d     = ((busy_q & ~clr_mask_s) | set_mask_s) & ~REG_ONE_HOT0;

        wb_err_d   = (rf_rd_d != {REG_ADDR_W{1'b0}}) & ~busy_d[rf_rd_d];
    end

    // Scoreboard and registered write port
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            busy_q    <= {NUM_REGS{1'b0}};
            rf_rd_q   <= {REG_ADDR_W{1'b0}};
            rf_data_q <= {XLEN{1'b0}};
            wb_err_q  <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
            wb_err_q  <= wb_err_d;
        end
    end

    assign bus.issue_stall_o = stall_s;
    assign bus.alu_ready_o   = gnt_s[0];
    assign bus.lsu_ready_o   = gnt_s[1];
    assign bus.rf_rd_o       = rf_rd_q;
    assign bus.rf_data_o     = rf_data_q;
    assign bus.wb_err_o      = wb_err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a spec-level model checked every
// cycle plus hand-computed expectations for each scenario.
module tb_regfile_wb_arbiter;
    import core_pkg::*;

    logic clk;
    logic rstn;
    int   n_checks = 0;
    int   n_fail   = 0;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter dut (
        .clk    (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file sink: writes whenever rd != 0
    logic [31:0] rf_mem [NUM_REGS] = '{default: 32'd0};
    int          wr_cnt [NUM_REGS] = '{default: 0};
    always @(posedge clk) begin
        if (bus.rf_rd_o != 5'd0) begin
            rf_mem[bus.rf_rd_o] <= bus.rf_data_o;
            wr_cnt[bus.rf_rd_o] <= wr_cnt[bus.rf_rd_o] + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: busy set, tie-break owner, and the write port contents
    bit          m_busy [NUM_REGS];
    bit          m_alu_tie;
    int          m_rd;
    logic [31:0] m_data;
    bit          m_err;

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_alu_tie = 1'b1;
        m_rd      = 0;
        m_data    = 32'd0;
        m_err     = 1'b0;
    endtask

    initial begin
        bit e_stall, e_alu, e_lsu;
        model_reset();
        forever begin
            @(negedge clk);
            if (!rstn) model_reset();
            e_stall = bus.issue_valid_i && (m_busy[bus.issue_rs1_i] ||
                      m_busy[bus.issue_rs2_i] || m_busy[bus.issue_rd_i]);
            e_alu   = bus.alu_valid_i && (!bus.lsu_valid_i || m_alu_tie);
            e_lsu   = bus.lsu_valid_i && !e_alu;
            chk("m_stall",     32'(bus.issue_stall_o), 32'(e_stall));
            chk("m_alu_ready", 32'(bus.alu_ready_o),   32'(e_alu));
            chk("m_lsu_ready", 32'(bus.lsu_ready_o),   32'(e_lsu));
            chk("m_rf_rd",     32'(bus.rf_rd_o),       32'(m_rd));
            chk("m_wb_err",    32'(bus.wb_err_o),      32'(m_err));
            if (m_rd != 0) chk("m_rf_data", bus.rf_data_o, m_data);
            if (rstn) begin
                if (m_rd != 0) m_busy[m_rd] = 1'b0;
                if (bus.issue_valid_i && !e_stall && bus.issue_rd_i != 5'd0)
                    m_busy[bus.issue_rd_i] = 1'b1;
                if (bus.alu_valid_i && bus.lsu_valid_i) m_alu_tie = !m_alu_tie;
                if (e_alu) begin
                    m_rd = int'(bus.alu_rd_i);  m_data = bus.alu_data_i;
                end else if (e_lsu) begin
                    m_rd = int'(bus.lsu_rd_i);  m_data = bus.lsu_data_i;
                end else begin
                    m_rd = 0;                   m_data = 32'd0;
                end
                m_err = (m_rd != 0) && !m_busy[m_rd];
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [19:0] rd_seq;
        logic [3:0]  alu_g, lsu_g;

        rstn = 1'b0;
        bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd0;
        bus.issue_rs1_i   = 5'd1; bus.issue_rs2_i = 5'd2;
        bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd0; bus.alu_data_i = 32'd0;
        bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd0; bus.lsu_data_i = 32'd0;

        // 1: reset with both sources valid, then release
        cyc(); cyc();
        @(negedge clk);
        chk("t1_rst_rf_rd", 32'(bus.rf_rd_o), 32'd0);
        chk("t1_rst_stall", 32'(bus.issue_stall_o), 32'd0);
        cyc(); rstn = 1'b1;
        @(negedge clk);
        chk("t1_first_alu", 32'(bus.alu_ready_o), 32'd1);
        chk("t1_first_lsu", 32'(bus.lsu_ready_o), 32'd0);
        cyc();
        @(negedge clk);
        chk("t1_second_lsu", 32'(bus.lsu_ready_o), 32'd1);
        cyc(); bus.alu_valid_i = 1'b0; bus.lsu_valid_i = 1'b0; bus.issue_valid_i = 1'b0;

        // 2: RAW on x5 released by an ALU writeback
        cyc(); bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd5;
        bus.issue_rs1_i = 5'd0; bus.issue_rs2_i = 5'd0;
        @(negedge clk);
        chk("t2_issue_ok", 32'(bus.issue_stall_o), 32'd0);
        cyc(); bus.issue_rd_i = 5'd0; bus.issue_rs1_i = 5'd5;
        @(negedge clk);
        chk("t2_stall", 32'(bus.issue_stall_o), 32'd1);
        cyc(); bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd5; bus.alu_data_i = 32'hDEADBEEF;
        @(negedge clk);
        chk("t2_alu_ready", 32'(bus.alu_ready_o), 32'd1);
        cyc(); bus.alu_valid_i = 1'b0;
        @(negedge clk);
        chk("t2_rf_rd", 32'(bus.rf_rd_o), 32'd5);
        chk("t2_rf_data", bus.rf_data_o, 32'hDEADBEEF);
        chk("t2_still_stall", 32'(bus.issue_stall_o), 32'd1);
        cyc();
        @(negedge clk);
        chk("t2_stall_drop", 32'(bus.issue_stall_o), 32'd0);
        chk("t2_x5", rf_mem[5], 32'hDEADBEEF);
        cyc(); bus.issue_valid_i = 1'b0; bus.issue_rs1_i = 5'd0;

        // 3: contested ALU x3 / LSU x4, sources hold until accepted
        cyc(); bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd3;
        cyc(); bus.issue_rd_i = 5'd4;
        cyc(); bus.issue_valid_i = 1'b0; bus.issue_rd_i = 5'd0;
        bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd3; bus.alu_data_i = 32'h3333_0003;
        bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd4; bus.lsu_data_i = 32'h4444_0004;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rd_seq[i*5 +: 5] = bus.rf_rd_o;
            alu_g[i] = bus.alu_ready_o;
            lsu_g[i] = bus.lsu_ready_o;
            chk("t3_not_both", 32'(bus.alu_ready_o & bus.lsu_ready_o), 32'd0);
            cyc();
            if (alu_g[i]) bus.alu_valid_i = 1'b0;
            if (lsu_g[i]) bus.lsu_valid_i = 1'b0;
        end
        chk("t3_rd_seq", 32'(rd_seq), 32'({5'd0, 5'd4, 5'd3, 5'd0}));
        chk("t3_alu_grants", 32'(alu_g), 32'h1);
        chk("t3_lsu_grants", 32'(lsu_g), 32'h2);
        chk("t3_x3", rf_mem[3], 32'h3333_0003);

        // 4: ALU writeback to x0
        bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd0; bus.alu_data_i = 32'h0000_1234;
        @(negedge clk);
        chk("t4_alu_ready", 32'(bus.alu_ready_o), 32'd1);
        cyc(); bus.alu_valid_i = 1'b0;
        @(negedge clk);
        chk("t4_rf_rd", 32'(bus.rf_rd_o), 32'd0);
        chk("t4_wb_err", 32'(bus.wb_err_o), 32'd0);

        // 5: LSU writeback to non-busy x7
        cyc(); bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd7; bus.lsu_data_i = 32'h0000_0077;
        @(negedge clk);
        chk("t5_lsu_ready", 32'(bus.lsu_ready_o), 32'd1);
        cyc(); bus.lsu_valid_i = 1'b0;
        @(negedge clk);
        chk("t5_err_pulse", 32'(bus.wb_err_o), 32'd1);
        chk("t5_rf_rd", 32'(bus.rf_rd_o), 32'd7);
        cyc();
        @(negedge clk);
        chk("t5_err_gone", 32'(bus.wb_err_o), 32'd0);
        chk("t5_x7", rf_mem[7], 32'h0000_0077);

        // 6: reset while an x9 write is pending in the write port
        cyc(); bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd9;
        cyc(); bus.issue_valid_i = 1'b0; bus.issue_rd_i = 5'd0;
        bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd9; bus.alu_data_i = 32'h0000_0099;
        @(negedge clk);
        chk("t6_alu_ready", 32'(bus.alu_ready_o), 32'd1);
        cyc(); bus.alu_valid_i = 1'b0; rstn = 1'b0;
        @(negedge clk);
        chk("t6_rst_rf_rd", 32'(bus.rf_rd_o), 32'd0);
        cyc(); rstn = 1'b1;
        bus.issue_valid_i = 1'b1; bus.issue_rs1_i = 5'd9;
        @(negedge clk);
        chk("t6_busy_clear", 32'(bus.issue_stall_o), 32'd0);
        cyc(); bus.issue_valid_i = 1'b0; bus.issue_rs1_i = 5'd0;
        cyc(); cyc();
        chk("t6_x9_writes", 32'(wr_cnt[9]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Sole owner of the register file's write port (rd / data_rd_i).
- Arbitrates the ALU and LSU writeback streams onto that port using a valid/ready handshake.
- Keeps a per-register busy scoreboard that stalls issue on RAW/WAW hazards. There is no bypass network.
- Sits between the decode/issue stage, the execute units, and the register file.

Parameters:
- XLEN, 32, data width of writeback and register file.
- NUM_REGS, 32, number of architectural registers. Address width is clog2(NUM_REGS) = 5.

Ports:
- clk  in  1  core clock
- rstn_i  in  1  asynchronous active-low reset
- issue_valid_i  in  1  decode presents an instruction
- issue_rd_i  in  5  destination register; 0 means no write
- issue_rs1_i  in  5  source register 1
- issue_rs2_i  in  5  source register 2
- issue_stall_o  out  1  hazard; decode holds its instruction
- alu_valid_i  in  1  ALU writeback request
- alu_rd_i  in  5  ALU destination
- alu_data_i  in  XLEN  ALU result
- alu_ready_o  out  1  ALU request accepted this cycle
- lsu_valid_i  in  1  LSU writeback request
- lsu_rd_i  in  5  LSU destination
- lsu_data_i  in  XLEN  load data
- lsu_ready_o  out  1  LSU request accepted this cycle
- rf_rd_o  out  5  to register file rd; 0 = no write
- rf_data_o  out  XLEN  to register file data_rd_i
- wb_err_o  out  1  one-cycle pulse: writeback to a register that is not busy

Behaviour:
- Reset: busy_q = 0 for all registers, rf_rd_o = 0, rf_data_o = 0, last_grant_q = LSU, wb_err_o = 0.
  - Reset mid-operation discards all pending state; no write reaches the register file afterwards.
- Register file contract: it writes every cycle whenever rd != 0.
  - rf_rd_o must therefore be 0 in every cycle without an accepted writeback. It is never left holding a stale address.
- Hazard check (combinational, on busy_q only):
  - issue_stall_o = issue_valid_i & (busy_q[rs1] | busy_q[rs2] | busy_q[rd]).
  - Register 0 is never busy.
- Issue acceptance:
  - Accepted = issue_valid_i & !issue_stall_o.
  - If accepted and rd != 0, set busy_q[rd] at the next edge.
- Arbitration (combinational grant):
  - Only one valid source: that source is granted.
  - Both valid: round-robin. Grant the source that was not last_grant_q, then update last_grant_q.
  - last_grant_q changes only on contested cycles.
  - ready_o is asserted only for the granted source. A source with valid & !ready must hold rd/data stable.
  - A request with rd = 0 is accepted but produces rf_rd_o = 0.
- Output register:
  - Granted rd/data are registered into rf_rd_o/rf_data_o at the next edge, giving one cycle of latency.
  - The register file captures the value one edge later. Source data becomes readable 2 cycles after the handshake.
- Busy clear:
  - Clear busy_q[rf_rd_o] on the same edge the register file captures the write.
  - The stall for a dependent instruction therefore drops in the cycle its operand is readable.
- Same-index set and clear on the same edge: set wins.
  - In practice unreachable, because a busy rd stalls issue; the rule is kept for safety.
- wb_err_o: pulses in the cycle rf_rd_o != 0 and busy_q[rf_rd_o] = 0.
  - The write still proceeds.
- Throughput: one writeback per cycle; the losing source waits at least one cycle.

Decomposition:
- Shared package core_pkg holds:
  - XLEN and REG_ADDR_W constants.
  - typedef wb_req_t {valid, rd, data}.
  - enum wb_src_e {WB_ALU, WB_LSU}.
- One sub-module, wb_rr_arbiter: a 2-way round-robin arbiter with a last-grant register, reusable for other shared ports.
- The scoreboard stays inline.

Test Plan:
1. Reset with both sources valid, then release. Required: rf_rd_o = 0 and stall = 0 during reset; after release the first grant is ALU (last_grant = LSU).
2. Issue rd = 5, then issue rs1 = 5 next cycle. Required: stall = 1 until ALU writes x5 = 0xDEADBEEF. rf_rd_o = 5 one cycle after the handshake; stall drops the following cycle; the register file then reads 0xDEADBEEF.
3. ALU (rd = 3) and LSU (rd = 4) valid for 4 cycles with sources holding. Required: grants alternate ALU, LSU; rf_rd_o sequence 3, 4 (then 0 once both are accepted); ready is never high for both at once.
4. ALU writeback with rd = 0 and data 0x1234. Required: alu_ready_o = 1, rf_rd_o stays 0, wb_err_o = 0.
5. LSU writeback to non-busy x7. Required: wb_err_o pulses for exactly 1 cycle; x7 is still written.
6. Set x9 busy, then assert rstn_i = 0 while an x9 write is pending. Required: after reset busy_q = 0, rf_rd_o = 0, and x9 is not written.
